// File: rtl/cache_def.sv
// Shared cache/memory types: request/response structs, line width and the
// main-memory FSM state encoding.
package cache_def;

  localparam int MEM_LINE_W = 128;

  typedef struct packed {
    logic [31:0]           addr;
    logic [MEM_LINE_W-1:0] data;
    logic                  rw;
    logic                  valid;
  } mem_req_type;

  typedef struct packed {
    logic [MEM_LINE_W-1:0] data;
    logic                  ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } mem_state_e;

endpackage

// File: rtl/dm_main_mem_array.sv
// Main-memory line storage: one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset.
module dm_main_mem_array
  import cache_def::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [MEM_LINE_W-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [MEM_LINE_W-1:0] rdata
);

  logic [MEM_LINE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dm_main_mem.sv
// Fixed-latency main memory behind a direct-mapped cache controller.
// Optional read/write statistics counters are built when MEM_STATS_EN is defined.
module dm_main_mem
  import cache_def::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 1024
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output mem_state_e   state_o
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]  rd_cnt_o,
  output logic [15:0]  wr_cnt_o
`endif
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [7:0] LOAD_CNT = 8'(LATENCY - 1);

  mem_state_e            state_q, state_d;
  logic [7:0]            cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [MEM_LINE_W-1:0] wdata_q;
  logic                  rw_q;
  logic                  accept;
  logic                  respond;
  logic [MEM_LINE_W-1:0] rd_line;
  logic                  unused_addr_bits;

  // Handshake: mem_req.valid is taken only in IDLE or RESPOND (no queueing, no
  // backpressure); mem_data.ready is a one-cycle strobe that completes the request.
  assign accept  = mem_req.valid && (state_q == IDLE || state_q == RESPOND);
  assign respond = (state_q == RESPOND);
  assign state_o = state_q;

  assign unused_addr_bits = ^{mem_req.addr[31:4+IDX_W], mem_req.addr[3:0]};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_req.valid) state_d = (LATENCY == 1) ? RESPOND : BUSY;
      BUSY:    if (cnt_q <= 8'd1) state_d = RESPOND;
      RESPOND: state_d = mem_req.valid ? ((LATENCY == 1) ? RESPOND : BUSY) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The counter reaches 0 on the same edge that enters RESPOND.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
    end else if (accept) begin
      cnt_q   <= LOAD_CNT;
      idx_q   <= mem_req.addr[4 +: IDX_W];
      wdata_q <= mem_req.data;
      rw_q    <= mem_req.rw;
    end else if (state_q == BUSY && cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  always_comb begin
    mem_data.ready = respond;
    mem_data.data  = '0;
    if (respond && !rw_q) mem_data.data = rd_line;
  end

  dm_main_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i (clk_i),
    .we    (respond && rw_q),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (idx_q),
    .rdata (rd_line)
  );

`ifdef MEM_STATS_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_cnt_o <= 16'd0;
      wr_cnt_o <= 16'd0;
    end else if (respond) begin
      if (!rw_q && rd_cnt_o != 16'hFFFF) rd_cnt_o <= rd_cnt_o + 16'd1;
      if (rw_q  && wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_main_mem.sv
// Directed bench for dm_main_mem: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_dm_main_mem;
  import cache_def::*;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         reset_ni;
  mem_req_type  req4, req1;
  mem_data_type rsp4, rsp1;
  mem_state_e   st4, st1;
`ifdef MEM_STATS_EN
  logic [15:0]  rd4, wr4, rd1, wr1;
`endif

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];

  dm_main_mem #(.LATENCY(4), .DEPTH(1024)) u_dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .mem_req  (req4),
    .mem_data (rsp4),
    .state_o  (st4)
`ifdef MEM_STATS_EN
    ,
    .rd_cnt_o (rd4),
    .wr_cnt_o (wr4)
`endif
  );

  dm_main_mem #(.LATENCY(1), .DEPTH(1024)) u_dut1 (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .mem_req  (req1),
    .mem_data (rsp1),
    .state_o  (st1)
`ifdef MEM_STATS_EN
    ,
    .rd_cnt_o (rd1),
    .wr_cnt_o (wr1)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue4(input logic [31:0] addr, input logic [127:0] data, input logic rw);
    req4.addr  = addr;
    req4.data  = data;
    req4.rw    = rw;
    req4.valid = 1'b1;
  endtask

  // Accept edge counts as cycle 1; returns the cycle on which ready is seen.
  task automatic wait4(output int lat, output logic [127:0] rdata);
    @(posedge clk_i);
    #1;
    req4.valid = 1'b0;
    lat = 1;
    while (!rsp4.ready && lat < 300) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    rdata = rsp4.data;
  endtask

  task automatic issue1(input logic [31:0] addr, input logic [127:0] data, input logic rw);
    req1.addr  = addr;
    req1.data  = data;
    req1.rw    = rw;
    req1.valid = 1'b1;
  endtask

  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] P0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] P1 = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] W1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D2 = 128'hCAFE_0002_CAFE_0002_CAFE_0002_CAFE_0002;
  localparam logic [127:0] D3 = 128'hF00D_0003_F00D_0003_F00D_0003_F00D_0003;

  logic [31:0]  b2b_addr[4];
  logic [127:0] b2b_data[4];
  logic         b2b_rw[4];
  logic [127:0] b2b_exp[4];

  initial begin
    int           lat;
    int           pulses;
    logic         seen;
    logic [127:0] rd;
    logic [127:0] got;

    b2b_addr = '{32'h0000_0020, 32'h0000_0020, 32'h0000_4030, 32'h0000_0030};
    b2b_data = '{D2, 128'd0, D3, 128'd0};
    b2b_rw   = '{1'b1, 1'b0, 1'b1, 1'b0};
    b2b_exp  = '{128'd0, D2, 128'd0, D3};

    reset_ni = 1'b0;
    req4     = '0;
    req1     = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready4", 128'(rsp4.ready), 128'd0);
    check("rst_data4", rsp4.data, 128'd0);
    check("rst_state4", 128'(st4), 128'(IDLE));
    check("rst_ready1", 128'(rsp1.ready), 128'd0);
    reset_ni = 1'b1;
    step();

    // Write then read the same line with LATENCY=4.
    issue4(32'h0000_0010, A5, 1'b1);
    wait4(lat, rd);
    check("wr_latency", 128'(lat), 128'd4);
    check("wr_resp_data", rd, 128'd0);
    step();
    check("wr_ready_drop", 128'(rsp4.ready), 128'd0);
    check("wr_back_idle", 128'(st4), 128'(IDLE));
    issue4(32'h0000_0010, 128'd0, 1'b0);
    wait4(lat, rd);
    check("rd_latency", 128'(lat), 128'd4);
    check("rd_data", rd, A5);
    step();

    // valid held during the three BUSY edges must not be taken.
    issue4(32'h0000_0010, 128'd0, 1'b0);
    @(posedge clk_i);
    #1;
    pulses = 0;
    got    = '0;
    for (int i = 0; i < 13; i++) begin
      req4.valid = (i < 3);
      req4.addr  = 32'h0000_0020 + 32'(i * 16);
      req4.rw    = 1'b0;
      @(posedge clk_i);
      #1;
      if (rsp4.ready) begin
        pulses++;
        got = rsp4.data;
      end
    end
    check("busy_ignore_pulses", 128'(pulses), 128'd1);
    check("busy_ignore_data", got, A5);

    // Reset during BUSY drops the pending write; array contents survive.
    issue4(32'h0000_0050, P0, 1'b1);
    wait4(lat, rd);
    step();
    issue4(32'h0000_0050, P1, 1'b1);
    @(posedge clk_i);
    #1;
    req4.valid = 1'b0;
    step();
    reset_ni = 1'b0;
    #1;
    check("midrst_ready", 128'(rsp4.ready), 128'd0);
    check("midrst_state", 128'(st4), 128'(IDLE));
    step();
    reset_ni = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= rsp4.ready;
    end
    check("midrst_no_ready", 128'(seen), 128'd0);
    issue4(32'h0000_0050, 128'd0, 1'b0);
    wait4(lat, rd);
    check("midrst_old_data", rd, P0);
    step();

    // Write index 1, then an aliased read issued in the RESPOND cycle.
    issue4(32'h0000_0010, W1, 1'b1);
    wait4(lat, rd);
    check("b2b_wr_latency", 128'(lat), 128'd4);
    issue4(32'h0000_4010, 128'd0, 1'b0);
    wait4(lat, rd);
    check("b2b_rd_latency", 128'(lat), 128'd4);
    check("b2b_alias_data", rd, W1);
    step();

    // LATENCY=1: four back-to-back requests give four consecutive ready cycles.
    for (int i = 0; i < 4; i++) begin
      issue1(b2b_addr[i], b2b_data[i], b2b_rw[i]);
      exp_q.push_back(b2b_exp[i]);
      step();
      check($sformatf("lat1_ready%0d", i), 128'(rsp1.ready), 128'd1);
      check($sformatf("lat1_data%0d", i), rsp1.data, exp_q.pop_front());
    end
    req1.valid = 1'b0;
    step();
    check("lat1_ready_end", 128'(rsp1.ready), 128'd0);

`ifdef MEM_STATS_EN
    reset_ni = 1'b0;
    #2;
    reset_ni = 1'b1;
    check("stat_rd_rst", 128'(rd1), 128'd0);
    check("stat_wr_rst", 128'(wr1), 128'd0);
    for (int i = 0; i < 5; i++) begin
      issue1(32'h0000_0060, 128'(i), (i == 1 || i == 3 || i == 4));
      step();
    end
    req1.valid = 1'b0;
    step();
    check("stat_rd2", 128'(rd1), 128'd2);
    check("stat_wr3", 128'(wr1), 128'd3);
    issue1(32'h0000_0060, 128'd0, 1'b0);
    repeat (70000) @(posedge clk_i);
    #1;
    req1.valid = 1'b0;
    step();
    check("stat_rd_sat", 128'(rd1), 128'hFFFF);
    check("stat_wr_hold", 128'(wr1), 128'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_main_mem.md
DM_MAIN_MEM -- requirements
Module: dm_main_mem

Interface
REQ-001 SHALL have parameter LATENCY, default 4, cycles from request acceptance to ready pulse; legal range 1..255.
REQ-002 SHALL have parameter DEPTH, default 1024, number of 128-bit lines; power of two.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-004 SHALL have port reset_ni, input, 1 bit, reset; asynchronous and active-low.
REQ-005 SHALL have port mem_req, input, mem_req_type (addr 32, data 128, rw, valid), request from the cache controller.
REQ-006 SHALL have port mem_data, output, mem_data_type (data 128, ready), response to the cache controller.
REQ-007 SHALL have ports rd_cnt_o and wr_cnt_o, output, 16 bits each, only when MEM_STATS_EN is defined.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY and RESPOND.
REQ-009 In IDLE with mem_req.valid=1, SHALL capture addr, data and rw on the clock edge and enter BUSY with counter loaded to LATENCY-1; for LATENCY=1, SHALL go directly to RESPOND.
REQ-010 In BUSY, SHALL decrement the counter each cycle and enter RESPOND when it reaches 0.
REQ-011 mem_data.ready SHALL be 1 for exactly one cycle (RESPOND), LATENCY cycles after the accepting edge; otherwise 0.
REQ-012 Line index SHALL be captured addr[4+log2(DEPTH)-1:4]; upper address bits and addr[3:0] SHALL be ignored (aliasing wraps).
REQ-013 Read (rw=0): during RESPOND, mem_data.data SHALL equal the stored line at the captured index; otherwise mem_data.data SHALL be 0.
REQ-014 Write (rw=1): the captured 128-bit data SHALL commit to the array on the edge ending RESPOND; mem_data.data SHALL be 0 during a write response.
REQ-015 mem_req.valid in BUSY SHALL be ignored; no queueing.
REQ-016 mem_req.valid=1 in RESPOND SHALL be accepted on the same edge (back-to-back, e.g. write-back followed by allocate), entering BUSY or RESPOND per REQ-009.
REQ-017 A read accepted back-to-back after a write to the same index SHALL return the newly written data.
REQ-018 In RESPOND without a new request, SHALL return to IDLE.

Reset
REQ-019 reset_ni=0 SHALL immediately force state IDLE, counter 0, mem_data.ready 0, mem_data.data 0, and captured request cleared, including mid-transaction (a pending write is dropped).
REQ-020 Array contents SHALL NOT be reset; they hold across reset.

Configuration
REQ-021 With MEM_STATS_EN defined, rd_cnt_o/wr_cnt_o SHALL increment on each read/write RESPOND cycle, saturate at 16'hFFFF, and reset to 0.
REQ-022 Without MEM_STATS_EN, the counter ports and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-023 mem_req_type and mem_data_type SHALL come from the shared cache_def package; the FSM state enum and MEM_LINE_W=128 SHALL be added to cache_def.
REQ-024 The line array SHALL be a sub-module dm_main_mem_array (one synchronous write port and one read port); the FSM, counter and capture registers SHALL reside in dm_main_mem.

Verification
REQ-025 Write addr=32'h0000_0010, data=128'hA5..A5, LATENCY=4 -> ready high exactly 4 cycles after accept; then read of the same addr -> data 128'hA5..A5.
REQ-026 Write index 1 immediately followed by a read of addr 32'h0000_4010 (same index, DEPTH=1024) in the RESPOND cycle -> accepted without an IDLE cycle; read returns the written line (alias plus back-to-back).
REQ-027 valid pulsed 3 times during BUSY -> ignored; exactly one ready pulse.
REQ-028 reset_ni low at BUSY cycle 2 of a write -> ready stays 0; later read of that line returns its pre-write contents.
REQ-029 LATENCY=1: request then 3 back-to-back requests -> ready high on 4 consecutive cycles.
REQ-030 MEM_STATS_EN: 2 reads and 3 writes -> rd_cnt_o=2, wr_cnt_o=3; 70000 reads -> rd_cnt_o=16'hFFFF.
